// File: rtl/pulse_pkg.sv
// Shared definitions for the single-pulse signalling blocks (generator and decoder).
// Default width limits live here so paired instances agree on what a legal pulse is.
package pulse_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2
  } decoder_state_t;

  localparam int DEFAULT_CNT_W     = 8;
  localparam int DEFAULT_MIN_WIDTH = 2;
  localparam int DEFAULT_MAX_WIDTH = 200;

endpackage

// File: rtl/pulse_width_decoder.sv
// Measures high pulses on a synchronous pulse line and reports the width with a
// one-cycle valid strobe, or a one-cycle error strobe for glitches and overlong pulses.
module pulse_width_decoder
  import pulse_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int MIN_WIDTH = DEFAULT_MIN_WIDTH,
  parameter int MAX_WIDTH = DEFAULT_MAX_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse,
  output logic [CNT_W-1:0] width,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  decoder_state_t   state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] width_reg, width_next;
  logic             valid_reg, valid_next;
  logic             error_reg, error_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= WAIT_LOW;
      count_reg <= '0;
      width_reg <= '0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      width_reg <= width_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    width_next = width_reg;
    valid_next = 1'b0;
    error_next = 1'b0;

    case (state_reg)
      // Arm only after a low sample, so a pulse already high or an overlong tail is ignored.
      WAIT_LOW: begin
        if (!pulse) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (pulse) begin
          state_next = MEASURE;
          count_next = ONE;
        end
      end

      MEASURE: begin
        if (pulse) begin
          if (count_reg < MAX_W) begin
            count_next = count_reg + ONE;
          end else begin
            error_next = 1'b1;
            width_next = MAX_W;
            state_next = WAIT_LOW;
          end
        end else begin
          if (count_reg >= MIN_W) begin
            valid_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
          width_next = count_reg;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = WAIT_LOW;
      end
    endcase
  end

  assign width = width_reg;
  assign valid = valid_reg;
  assign error = error_reg;
  assign busy  = (state_reg == MEASURE);

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder with MIN_WIDTH=2, MAX_WIDTH=8, CNT_W=4.
module tb_pulse_width_decoder;

  localparam int CNT_W     = 4;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             pulse = 1'b0;
  logic [CNT_W-1:0] width;
  logic             valid;
  logic             error;
  logic             busy;

  pulse_width_decoder #(
    .CNT_W    (CNT_W),
    .MIN_WIDTH(MIN_WIDTH),
    .MAX_WIDTH(MAX_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pulse(pulse),
    .width(width),
    .valid(valid),
    .error(error),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int w;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid || error) begin
        $display("strobe cycle=%0d valid=%0d error=%0d width=%0d", cyc, valid, error, width);
        if (valid && error) check("exclusive", 1, 0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, valid, error}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("kind_error", int'(error), int'(e.is_err));
          check("width", int'(width), e.w);
          check("latency", cyc, e.at);
        end
        if (valid) begin
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
      end
      if (busy) busy_cnt++;
    end
  end

  // Drive one pulse of h high samples followed by lo low samples; push expectation.
  task automatic send(input int h, input int lo);
    exp_t e;
    e.at = cyc + ((h > MAX_WIDTH) ? MAX_WIDTH + 1 : h + 1);
    if (h > MAX_WIDTH) begin
      e.is_err = 1'b1; e.w = MAX_WIDTH;
    end else if (h < MIN_WIDTH) begin
      e.is_err = 1'b1; e.w = h;
    end else begin
      e.is_err = 1'b0; e.w = h;
    end
    sb.push_back(e);
    $display("send high=%0d low=%0d expect err=%0d width=%0d", h, lo, e.is_err, e.w);
    pulse = 1'b1;
    repeat (h) @(posedge clock);
    #1 pulse = 1'b0;
    repeat (lo) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    pulse = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_width", int'(width), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_error", int'(error), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2) begin @(posedge clock); #1; end

    // Legal pulse with busy window
    busy_cnt = 0;
    send(3, 3);
    drain();
    check("busy_cycles", busy_cnt, 3);

    // Glitch and lower boundary
    send(1, 3);
    drain();
    send(2, 3);
    drain();

    // Upper boundary, overlong, recovery
    send(8, 3);
    drain();
    send(12, 4);
    drain();
    send(4, 3);
    drain();

    // Back-to-back pulses separated by one low sample
    send(3, 1);
    send(4, 3);
    drain();
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 5);

    // Reset released while the line is high: nothing measured
    pulse = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    busy_cnt = 0;
    repeat (5) begin @(posedge clock); #1; end
    check("hold_high_busy", busy_cnt, 0);
    check("hold_high_busy_now", int'(busy), 0);
    pulse = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    send(2, 3);
    drain();

    // Reset mid-measurement aborts asynchronously
    pulse = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("pre_abort_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_error", int'(error), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    pulse = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    check("abort_no_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
